// File: rtl/fsk4_cw_if.sv
// Codeword handshake between the CRC-8 encoder (master) and the
// 4-FSK symbol mapper (slave): a valid/ready pair carrying one 16-bit
// codeword {data[7:0], crc[7:0]} per transfer.
interface fsk4_cw_if;
    logic        cw_valid;
    logic [15:0] cw_data;
    logic        cw_ready;

    modport master (
        output cw_valid,
        output cw_data,
        input  cw_ready
    );

    modport slave (
        input  cw_valid,
        input  cw_data,
        output cw_ready
    );
endinterface

// File: rtl/fsk4_symbol_mapper.sv
// 4-FSK symbol mapper.
// Takes one 16-bit codeword per frame and emits a 4-symbol sync word
// followed by the codeword as 8 dibits (MSB first), each symbol held for
// SPS clock cycles. Every frame is exactly 12*SPS cycles long, and a new
// codeword can be accepted on the final cycle of a frame so back-to-back
// frames are gapless.
//
// Optional build macro FSK_GRAY_MAP_EN: when defined, each dibit is
// Gray-mapped to a tone index so adjacent tones differ by one bit;
// otherwise the tone index equals the dibit. Timing is identical.
module fsk4_symbol_mapper #(
    parameter int          SPS       = 16,
    parameter logic [7:0]  SYNC_WORD = 8'hB4
) (
    input  logic        clk,
    input  logic        rst_n,
    fsk4_cw_if.slave    cw,
    output logic        sym_valid,
    output logic [1:0]  sym,
    output logic        sym_strobe,
    output logic        busy,
    output logic        frame_done
);

    localparam int SCW = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [SCW-1:0] SAMP_LAST = SCW'(SPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [SCW-1:0] samp_cnt, samp_nxt;
    logic [2:0]     sym_cnt, sym_cnt_nxt;
    logic [15:0]    shreg, shreg_nxt;

    logic           sym_valid_nxt;
    logic [1:0]     sym_nxt;
    logic           sym_strobe_nxt;
    logic           busy_nxt;
    logic           frame_done_nxt;

    logic           last_samp;
    logic           frame_end;
    logic           xfer;

    // Dibit to tone index.
    function automatic logic [1:0] tone_map(input logic [1:0] d);
`ifdef FSK_GRAY_MAP_EN
        return {d[1], d[1] ^ d[0]};
`else
        return d;
`endif
    endfunction

    // Sync dibit for a given sync symbol position, MSB first.
    function automatic logic [1:0] sync_dibit(input logic [1:0] idx);
        logic [1:0] d;
        case (idx)
            2'd0:    d = SYNC_WORD[7:6];
            2'd1:    d = SYNC_WORD[5:4];
            2'd2:    d = SYNC_WORD[3:2];
            default: d = SYNC_WORD[1:0];
        endcase
        return d;
    endfunction

    assign last_samp = (samp_cnt == SAMP_LAST);
    // Last cycle of the last data symbol; only depends on registered state.
    assign frame_end = (state == DATA) && (sym_cnt == 3'd7) && last_samp;

    assign cw.cw_ready = (state == IDLE) || frame_end;
    assign xfer        = cw.cw_valid && cw.cw_ready;

    // Next-state, counters, shift register and next output values.
    always_comb begin
        state_nxt   = state;
        samp_nxt    = samp_cnt;
        sym_cnt_nxt = sym_cnt;
        shreg_nxt   = shreg;

        case (state)
            IDLE: begin
                if (xfer) begin
                    state_nxt   = SYNC;
                    samp_nxt    = '0;
                    sym_cnt_nxt = 3'd0;
                    shreg_nxt   = cw.cw_data;
                end
            end
            SYNC: begin
                if (last_samp) begin
                    samp_nxt = '0;
                    if (sym_cnt == 3'd3) begin
                        state_nxt   = DATA;
                        sym_cnt_nxt = 3'd0;
                    end else begin
                        sym_cnt_nxt = sym_cnt + 3'd1;
                    end
                end else begin
                    samp_nxt = samp_cnt + SCW'(1);
                end
            end
            DATA: begin
                if (last_samp) begin
                    samp_nxt = '0;
                    if (sym_cnt == 3'd7) begin
                        sym_cnt_nxt = 3'd0;
                        if (xfer) begin
                            state_nxt = SYNC;
                            shreg_nxt = cw.cw_data;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        sym_cnt_nxt = sym_cnt + 3'd1;
                        shreg_nxt   = {shreg[13:0], 2'b00};
                    end
                end else begin
                    samp_nxt = samp_cnt + SCW'(1);
                end
            end
            default: begin
                state_nxt   = IDLE;
                samp_nxt    = '0;
                sym_cnt_nxt = 3'd0;
            end
        endcase

        // Outputs describe the symbol slot the machine is entering.
        sym_valid_nxt  = (state_nxt != IDLE);
        busy_nxt       = (state_nxt != IDLE);
        sym_strobe_nxt = sym_valid_nxt && (samp_nxt == '0);
        frame_done_nxt = (state_nxt == DATA) && (sym_cnt_nxt == 3'd7) &&
                         (samp_nxt == SAMP_LAST);
        case (state_nxt)
            SYNC:    sym_nxt = tone_map(sync_dibit(sym_cnt_nxt[1:0]));
            DATA:    sym_nxt = tone_map(shreg_nxt[15:14]);
            default: sym_nxt = 2'd0;
        endcase
    end

    // State, counters, codeword and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            samp_cnt   <= '0;
            sym_cnt    <= 3'd0;
            shreg      <= 16'd0;
            sym_valid  <= 1'b0;
            sym        <= 2'd0;
            sym_strobe <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            samp_cnt   <= samp_nxt;
            sym_cnt    <= sym_cnt_nxt;
            shreg      <= shreg_nxt;
            sym_valid  <= sym_valid_nxt;
            sym        <= sym_nxt;
            sym_strobe <= sym_strobe_nxt;
            busy       <= busy_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule
